// File: rtl/fsm1_sched.sv
// fsm1_sched: round-robin two-requester command scheduler for fsm1_route.
// Optional grant counters are enabled with `define FSM1_SCHED_STATS_EN.
module fsm1_sched #(
  parameter int unsigned OBS_LAT = 1
) (
  input  logic       GCLK_Pad,
  input  logic       reset_Pad,
  input  logic       a_req,
  input  logic [2:0] a_cmd,
  output logic       a_ack,
  output logic [2:0] a_state,
  input  logic       b_req,
  input  logic [2:0] b_cmd,
  output logic       b_ack,
  output logic [2:0] b_state,
  output logic       fsm_input1,
  output logic       fsm_input2,
  output logic       fsm_reset,
  input  logic       state_obs0_Pad,
  input  logic       state_obs1_Pad,
  input  logic       output1_Pad,
`ifdef FSM1_SCHED_STATS_EN
  output logic [7:0] a_grants,
  output logic [7:0] b_grants,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(OBS_LAT);

  state_t     state_q;
  logic       ptr_q;
  logic       gnt_q;
  logic [3:0] cnt_q;
  logic [2:0] pulse_q;
  logic       a_ack_q;
  logic       b_ack_q;
  logic [2:0] a_st_q;
  logic [2:0] b_st_q;

  logic       gnt_b_d;
  logic [2:0] cmd_d;
  logic [2:0] pulse_d;
  logic [2:0] obs_d;

  // ptr_q=1 means B wins a tie
  assign gnt_b_d = b_req & (~a_req | ptr_q);
  assign cmd_d   = gnt_b_d ? b_cmd : a_cmd;
  assign pulse_d = cmd_d[2] ? 3'b100 : {1'b0, cmd_d[1:0]};
  assign obs_d   = {output1_Pad, state_obs1_Pad, state_obs0_Pad};

`ifdef FSM1_SCHED_STATS_EN
  logic [7:0] a_cnt_q;
  logic [7:0] b_cnt_q;
`endif

  always_ff @(posedge GCLK_Pad) begin
    if (!reset_Pad) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= 4'd0;
      pulse_q <= 3'b000;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_st_q  <= 3'b000;
      b_st_q  <= 3'b000;
`ifdef FSM1_SCHED_STATS_EN
      a_cnt_q <= 8'd0;
      b_cnt_q <= 8'd0;
`endif
    end else begin
      pulse_q <= 3'b000;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (a_req | b_req) begin
            state_q <= ISSUE;
            gnt_q   <= gnt_b_d;
            ptr_q   <= ~gnt_b_d;
            pulse_q <= pulse_d;
`ifdef FSM1_SCHED_STATS_EN
            if (gnt_b_d && b_cnt_q != 8'hFF)
              b_cnt_q <= b_cnt_q + 8'd1;
            if (!gnt_b_d && a_cnt_q != 8'hFF)
              a_cnt_q <= a_cnt_q + 8'd1;
`endif
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= LAT;
        end
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q <= RESP;
            if (gnt_q) begin
              b_st_q  <= obs_d;
              b_ack_q <= 1'b1;
            end else begin
              a_st_q  <= obs_d;
              a_ack_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fsm_reset  = pulse_q[2];
  assign fsm_input2 = pulse_q[1];
  assign fsm_input1 = pulse_q[0];
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_state    = a_st_q;
  assign b_state    = b_st_q;
  assign busy       = (state_q != IDLE);

`ifdef FSM1_SCHED_STATS_EN
  assign a_grants = a_cnt_q;
  assign b_grants = b_cnt_q;
`endif

endmodule

// File: tb/tb_fsm1_sched.sv
// tb_fsm1_sched: scoreboard bench for fsm1_sched at OBS_LAT=1,
// plus a directed latency check on a second instance at OBS_LAT=4.
module tb_fsm1_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, b_req;
  logic [2:0] a_cmd, b_cmd;
  logic       a_ack, b_ack;
  logic [2:0] a_state, b_state;
  logic       fsm_input1, fsm_input2, fsm_reset;
  logic [2:0] pads;
  logic       busy;

  logic       a4_req, b4_req;
  logic [2:0] a4_cmd, b4_cmd;
  logic       a4_ack, b4_ack;
  logic [2:0] a4_state, b4_state;
  logic       f4_in1, f4_in2, f4_rst;
  logic [2:0] pads4;
  logic       busy4;

`ifdef FSM1_SCHED_STATS_EN
  logic [7:0] a_grants, b_grants;
  logic [7:0] a4_grants, b4_grants;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsm1_sched #(.OBS_LAT(1)) u_dut (
    .GCLK_Pad(clk), .reset_Pad(rst_n),
    .a_req(a_req), .a_cmd(a_cmd), .a_ack(a_ack), .a_state(a_state),
    .b_req(b_req), .b_cmd(b_cmd), .b_ack(b_ack), .b_state(b_state),
    .fsm_input1(fsm_input1), .fsm_input2(fsm_input2),
    .fsm_reset(fsm_reset),
    .state_obs0_Pad(pads[0]), .state_obs1_Pad(pads[1]),
    .output1_Pad(pads[2]),
`ifdef FSM1_SCHED_STATS_EN
    .a_grants(a_grants), .b_grants(b_grants),
`endif
    .busy(busy)
  );

  fsm1_sched #(.OBS_LAT(4)) u_dut4 (
    .GCLK_Pad(clk), .reset_Pad(rst_n),
    .a_req(a4_req), .a_cmd(a4_cmd), .a_ack(a4_ack), .a_state(a4_state),
    .b_req(b4_req), .b_cmd(b4_cmd), .b_ack(b4_ack), .b_state(b4_state),
    .fsm_input1(f4_in1), .fsm_input2(f4_in2), .fsm_reset(f4_rst),
    .state_obs0_Pad(pads4[0]), .state_obs1_Pad(pads4[1]),
    .output1_Pad(pads4[2]),
`ifdef FSM1_SCHED_STATS_EN
    .a_grants(a4_grants), .b_grants(b4_grants),
`endif
    .busy(busy4)
  );

  typedef struct packed {
    logic       is_b;
    logic [2:0] st;
  } ack_t;

  ack_t       aq[$];
  logic [2:0] pq[$];
  logic [2:0] acmds[$];
  logic [2:0] bcmds[$];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_txn(input logic is_b, input logic [2:0] pul,
                         input logic [2:0] st);
    ack_t e;
    e.is_b = is_b;
    e.st   = st;
    pq.push_back(pul);
    aq.push_back(e);
  endtask

  // Requesters hold req while their command queue is non-empty
  initial begin
    forever begin
      @(negedge clk);
      if (a_ack && acmds.size() > 0) void'(acmds.pop_front());
      if (b_ack && bcmds.size() > 0) void'(bcmds.pop_front());
      a_req = (acmds.size() > 0);
      a_cmd = a_req ? acmds[0] : 3'b000;
      b_req = (bcmds.size() > 0);
      b_cmd = b_req ? bcmds[0] : 3'b000;
    end
  end

  logic prev_busy = 1'b0;
  int   issue_cyc = 0;

  always @(negedge clk) begin
    logic [2:0] pul;
    ack_t e;
    pul = {fsm_reset, fsm_input2, fsm_input1};
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: pulses %b", pul);
        end else begin
          chk("issue_pulses", {5'd0, pul}, {5'd0, pq.pop_front()});
        end
        issue_cyc = cyc;
      end else if (pul != 3'b000) begin
        chk("stray_pulse", {5'd0, pul}, 8'd0);
      end
      if (a_ack || b_ack) begin
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: a_ack %b b_ack %b", a_ack, b_ack);
        end else begin
          e = aq.pop_front();
          chk("ack_who", {6'd0, a_ack, b_ack},
              e.is_b ? 8'd1 : 8'd2);
          chk("ack_state", {5'd0, e.is_b ? b_state : a_state},
              {5'd0, e.st});
          chk("ack_latency", 8'(cyc - issue_cyc), 8'd2);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while ((aq.size() != 0 || acmds.size() != 0 ||
            bcmds.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d acks outstanding, need 0",
               aq.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    acmds.delete();
    bcmds.delete();
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run4(input logic is_b, input logic [2:0] exp_pul,
                      output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1)
        chk("p4_issue", {5'd0, f4_rst, f4_in2, f4_in1}, {5'd0, exp_pul});
      else if ({f4_rst, f4_in2, f4_in1} != 3'b000)
        chk("p4_stray", {5'd0, f4_rst, f4_in2, f4_in1}, 8'd0);
    end while (!(is_b ? b4_ack : a4_ack) && n < 20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    a_req  = 1'b0;
    b_req  = 1'b0;
    a_cmd  = 3'b000;
    b_cmd  = 3'b000;
    pads   = 3'b000;
    a4_req = 1'b0;
    b4_req = 1'b0;
    a4_cmd = 3'b000;
    b4_cmd = 3'b000;
    pads4  = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_acks", {6'd0, a_ack, b_ack}, 8'd0);
    chk("rst_states", {2'd0, a_state, b_state}, 8'd0);
    chk("rst_pulses", {5'd0, fsm_reset, fsm_input2, fsm_input1}, 8'd0);
    rst_n = 1'b1;

    // A alone, reset command
    exp_txn(1'b0, 3'b100, 3'b000);
    acmds.push_back(3'b100);
    drain(20);

    // tie from reset: A first, then B
    do_reset();
    pads = 3'b010;
    exp_txn(1'b0, 3'b011, 3'b010);
    exp_txn(1'b1, 3'b010, 3'b010);
    acmds.push_back(3'b011);
    bcmds.push_back(3'b010);
    drain(40);
    chk("tie_a_state", {5'd0, a_state}, 8'h02);

    // continuous requests alternate
    do_reset();
    pads = 3'b111;
    for (int i = 0; i < 3; i++) begin
      exp_txn(1'b0, 3'b001, 3'b111);
      exp_txn(1'b1, 3'b100, 3'b111);
      acmds.push_back(3'b001);
      bcmds.push_back(3'b110);
    end
    drain(100);
`ifdef FSM1_SCHED_STATS_EN
    chk("a_grants_6", a_grants, 8'd3);
    chk("b_grants_6", b_grants, 8'd3);
`endif

    // reset during WAIT drops the transaction
    pads = 3'b000;
    pq.push_back(3'b001);
    acmds.push_back(3'b001);
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_issue_seen", {7'd0, busy}, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    acmds.delete();
    a_req = 1'b0;
    @(negedge clk);
    chk("mid_busy", {7'd0, busy}, 8'd0);
    chk("mid_a_ack", {7'd0, a_ack}, 8'd0);
    chk("mid_a_state", {5'd0, a_state}, 8'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pads = 3'b011;
    exp_txn(1'b1, 3'b010, 3'b011);
    bcmds.push_back(3'b010);
    drain(20);

`ifdef FSM1_SCHED_STATS_EN
    do_reset();
    pads = 3'b000;
    for (int i = 0; i < 300; i++) begin
      exp_txn(1'b0, 3'b000, 3'b000);
      acmds.push_back(3'b000);
    end
    drain(2000);
    chk("a_grants_sat", a_grants, 8'd255);
    chk("b_grants_sat", b_grants, 8'd0);
`endif
    chk("pulse_q_empty", 8'(pq.size()), 8'd0);

    // OBS_LAT=4 instance
    @(negedge clk);
    pads4  = 3'b010;
    a4_cmd = 3'b001;
    a4_req = 1'b1;
    run4(1'b0, 3'b001, n);
    a4_req = 1'b0;
    chk("lat4_a_cycles", 8'(n), 8'd6);
    chk("lat4_a_state", {5'd0, a4_state}, 8'h02);
    @(negedge clk);
    pads4  = 3'b101;
    b4_cmd = 3'b000;
    b4_req = 1'b1;
    run4(1'b1, 3'b000, n);
    b4_req = 1'b0;
    chk("lat4_b_cycles", 8'(n), 8'd6);
    chk("lat4_b_state", {5'd0, b4_state}, 8'h05);
    chk("lat4_a_hold", {5'd0, a4_state}, 8'h02);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm1_sched.md
# fsm1_sched

Two-requester scheduler that owns the pulse inputs of the `fsm1_route` state machine. It arbitrates round-robin between requesters A and B and issues each granted command as a single-cycle pulse on `input1`/`input2`/`reset`. After a fixed observation latency it samples the FSM's state and output pads and returns them to the requester that issued the command. It sits between test/control logic and `fsm1_route`, so exactly one command pulse reaches the FSM per transaction.

## Interface
Parameters:
- `OBS_LAT`, default 1: cycles between the pulse cycle and the observation capture edge. Legal range 1..15.

Ports:
- `GCLK_Pad`, in, 1: single clock; all logic updates on its rising edge.
- `reset_Pad`, in, 1: reset, synchronous, active-low.
- `a_req`, in, 1: requester A transaction request; held until `a_ack`.
- `a_cmd`, in, 3: {rst, in2, in1} command for A; stable while `a_req` is high.
- `a_ack`, out, 1: one-cycle completion strobe to A.
- `a_state`, out, 3: {output1, obs1, obs0} captured for A's last transaction.
- `b_req`, `b_cmd`, `b_ack`, `b_state`: identical to the A ports, for requester B.
- `fsm_input1`, out, 1: pulse to `input1_Pad` of the FSM.
- `fsm_input2`, out, 1: pulse to `input2_Pad` of the FSM.
- `fsm_reset`, out, 1: pulse to `reset_Pad` of the FSM.
- `state_obs0_Pad`, in, 1: FSM state bit 0.
- `state_obs1_Pad`, in, 1: FSM state bit 1.
- `output1_Pad`, in, 1: FSM output.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: sample requests.
  - ISSUE: drive the pulse outputs.
  - WAIT: count `OBS_LAT` cycles.
  - RESP: assert the granted requester's ack.
- IDLE → ISSUE when `a_req` or `b_req` is high at the edge. Otherwise stay in IDLE.
- Grant and pointer:
  - Only one request high: that requester is granted.
  - Both high: the requester named by the round-robin pointer `ptr` is granted.
  - After every grant, `ptr` points to the requester that was not granted.
  - On reset, `ptr` points to A.
- The granted command is latched at the IDLE→ISSUE edge. Later changes to `*_cmd` are ignored.
- ISSUE, rst=1: only `fsm_reset` pulses; the in1/in2 bits are ignored.
- ISSUE, rst=0: `fsm_input1` = in1 and `fsm_input2` = in2. Both may pulse together.
- ISSUE, cmd 000: no pulse is issued, but the transaction still completes (a read of the FSM state).
- ISSUE → WAIT unconditionally. WAIT lasts exactly `OBS_LAT` cycles, counted by a 4-bit down-counter.
- At the edge ending the last WAIT cycle:
  - {`output1_Pad`, `state_obs1_Pad`, `state_obs0_Pad`} is captured into the granted requester's `*_state`.
  - The other requester's `*_state` holds its value.
- RESP: the granted requester's `*_ack` is high for exactly one cycle. RESP → IDLE.
- A requester seeing ack in cycle t must drive req low in cycle t+1. A req that is high in the IDLE cycle after RESP starts a new transaction.
- An ungranted request waits while asserted and is granted in the next IDLE cycle. Worst-case wait is one transaction.

## Timing
- Reset (`reset_Pad`=0 at an edge):
  - State → IDLE, `ptr` → A.
  - All outputs → 0, including `*_state` and `*_ack`.
  - An in-flight transaction is dropped: no ack, no further pulses.
  - Reset has priority over every other event.
- Transaction timing, request seen at the end of IDLE cycle 0:
  - ISSUE = cycle 1 (pulses high exactly this cycle).
  - WAIT = cycles 2..1+`OBS_LAT`.
  - RESP/ack = cycle 2+`OBS_LAT`.
- Back-to-back throughput is one transaction per 3+`OBS_LAT` cycles.
- Pulse outputs are registered and never high outside ISSUE.
- `*_state` updates only at the capture edge and is valid from the RESP cycle onward.

## Configuration
- `FSM1_SCHED_STATS_EN` defined:
  - Adds outputs `a_grants` and `b_grants` (8 bits each, reset 0).
  - Each increments on its requester's grant edge and saturates at 255.
- Macro undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then A issues cmd 100 alone, OBS_LAT=1:
  - `fsm_reset` is high in cycle 1 only, with `fsm_input1`=`fsm_input2`=0.
  - `a_ack` is high in cycle 3, with `a_state`=000.
- A and B both request from reset (`ptr`=A); A cmd 011, B cmd 010:
  - A is granted first (both inputs pulse); B is granted next (only `fsm_input2` pulses).
  - Exactly one ack per transaction, in order A then B.
- Both requesters hold req continuously for 6 transactions: grants alternate A,B,A,B,A,B. With `FSM1_SCHED_STATS_EN`, `a_grants`=`b_grants`=3.
- OBS_LAT=4, B cmd 000 with the FSM pads driven to 101:
  - No pulses are issued.
  - `b_ack` is high 6 cycles after the request edge, with `b_state`=101; `a_state` is unchanged.
- `reset_Pad` driven low during WAIT of an A transaction:
  - `a_ack` never asserts; `busy`=0 on the next cycle.
  - A new B request is then granted normally.
- With `FSM1_SCHED_STATS_EN`, 300 A-only transactions: `a_grants` saturates at 255.
